sw_job_dispatcher: RTL
======================

// Module: sw_job_dispatcher
// PURPOSE
//   Host-side initiator for SW_core. Collects one job (packed 2-bit-base reference and read
//   sequences) from a 32-bit word stream, issues it over SW_core's valid/ready input port,
//   waits for the score/row/column result and presents it on a result port. It is the
//   hardware counterpart of the bench driver, sitting between the host DMA and SW_core.
// PARAMETERS
//   WORD_W          32   stream word width; SEQ_W (256) must be a multiple of it
//   SEQ_W          256   packed bits per sequence in the stream (ref or read)
//   REF_MAX_LENGTH 256   SW_core reference capacity in bases
//   READ_MAX_LENGTH 128  SW_core read capacity in bases
//   REF_LENGTH     128   bases per job reference (SEQ_W/2)
//   READ_LENGTH    128   bases per job read (SEQ_W/2)
//   SCORE_W         16   signed score width (DP_SW_SCORE_BITWIDTH)
//   TIMEOUT       4096   max cycles waiting for a result; 0 disables
// PORTS
//   clk             in   1    clock
//   rst_n           in   1    asynchronous reset, active low
//   s_valid         in   1    stream word valid
//   s_ready         out  1    stream word accepted when s_valid&&s_ready
//   s_data          in   WORD_W  word; first word = MSBs of ref, then ref..., then read
//   sw_o_ready      in   1    SW_core idle/ready for a job
//   sw_i_valid      out  1    job valid to SW_core
//   sw_seq_ref      out  2*REF_MAX_LENGTH   {ref SEQ_W bits, zero pad}
//   sw_seq_read     out  2*READ_MAX_LENGTH  {read SEQ_W bits, zero pad}
//   sw_ref_len      out  clog2(REF_MAX_LENGTH)+1   REF_LENGTH (1-based)
//   sw_read_len     out  clog2(READ_MAX_LENGTH)+1  READ_LENGTH (1-based)
//   sw_i_ready      out  1    dispatcher can take a result
//   sw_o_valid      in   1    result valid from SW_core
//   sw_score        in   SCORE_W (signed)  alignment score
//   sw_row          in   clog2(READ_MAX_LENGTH)  best row
//   sw_col          in   clog2(REF_MAX_LENGTH)   best column
//   m_valid         out  1    result valid
//   m_ready         in   1    result consumer ready
//   m_score/m_row/m_col out  as sw_*  captured result
//   m_timeout       out  1    result slot is a timeout (score/row/col = 0)
//   job_cnt         out  16   completed jobs (wraps 0xFFFF->0)
// BEHAVIOUR
//   - Reset: state LOAD, word counter 0, s_ready=0 for first cycle after release then 1,
//     sw_i_valid=0, sw_i_ready=0, all sw_seq_*/sw_*_len=0, m_valid=0, m_*=0, job_cnt=0.
//   - LOAD: s_ready=1; each accepted word shifts into a 2*SEQ_W buffer MSB-first; after
//     2*SEQ_W/WORD_W words (16 default) -> ISSUE next cycle. No gaps required; s_valid low stalls.
//   - ISSUE: sw_i_valid=1 with buffer, pad and lengths driven and held stable until
//     sw_i_valid&&sw_o_ready; then -> WAIT, sw_i_valid=0 and sw_seq_*/len return to 0.
//   - WAIT: sw_i_ready=1; on sw_o_valid capture score/row/col, m_timeout=0 -> OUT.
//     Timer counts cycles in WAIT; reaching TIMEOUT -> OUT with m_timeout=1, fields 0.
//     sw_o_valid on the same cycle as the timeout hit: result wins, m_timeout=0.
//   - OUT: m_valid=1, fields stable until m_valid&&m_ready; then job_cnt+1, -> LOAD.
//     m_ready high on entry: transfer takes exactly one cycle of m_valid.
//   - s_ready=0 in ISSUE/WAIT/OUT (one job in flight). sw_o_valid outside WAIT is ignored.
//   - Latency: last stream word to sw_i_valid = 1 cycle; sw_o_valid to m_valid = 1 cycle.
//   - rst_n low mid-job: immediate abort, partial job discarded, all outputs to reset values.
// TESTING
//   - 16 words, ref=0x0123...cdef x4, read=0xffff...0000; core ready -> sw_seq_ref upper 256b
//     equal ref, lower bits 0, sw_ref_len=128, sw_read_len=128, sw_i_valid 1 cycle.
//   - sw_o_ready held low 20 cycles in ISSUE -> sw_i_valid and data stable all 20 cycles.
//   - sw_o_valid with score=-5,row=127,col=200 -> m_score=-5,m_row=127,m_col=200 next cycle, m_timeout=0.
//   - m_ready low 10 cycles -> m_valid/fields held; s_ready=0; job_cnt increments once.
//   - TIMEOUT=16, no sw_o_valid -> m_valid after 16 WAIT cycles, m_timeout=1, fields 0.
//   - rst_n low after 7 words, then full 16-word job -> correct job, no stale words.

Source files
------------

// File: rtl/sw_job_dispatcher.sv
// Host-side job initiator for SW_core: gathers one packed ref/read job from a word stream,
// issues it to the core, waits (bounded by a timeout) for the result and presents it downstream.
module sw_job_dispatcher #(
    parameter int WORD_W          = 32,
    parameter int SEQ_W           = 256,
    parameter int REF_MAX_LENGTH  = 256,
    parameter int READ_MAX_LENGTH = 128,
    parameter int REF_LENGTH      = SEQ_W / 2,
    parameter int READ_LENGTH     = SEQ_W / 2,
    parameter int SCORE_W         = 16,
    parameter int TIMEOUT         = 4096
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [WORD_W-1:0]                    s_data,
    input  logic                                 sw_o_ready,
    output logic                                 sw_i_valid,
    output logic [2*REF_MAX_LENGTH-1:0]          sw_seq_ref,
    output logic [2*READ_MAX_LENGTH-1:0]         sw_seq_read,
    output logic [$clog2(REF_MAX_LENGTH):0]      sw_ref_len,
    output logic [$clog2(READ_MAX_LENGTH):0]     sw_read_len,
    output logic                                 sw_i_ready,
    input  logic                                 sw_o_valid,
    input  logic signed [SCORE_W-1:0]            sw_score,
    input  logic [$clog2(READ_MAX_LENGTH)-1:0]   sw_row,
    input  logic [$clog2(REF_MAX_LENGTH)-1:0]    sw_col,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic signed [SCORE_W-1:0]            m_score,
    output logic [$clog2(READ_MAX_LENGTH)-1:0]   m_row,
    output logic [$clog2(REF_MAX_LENGTH)-1:0]    m_col,
    output logic                                 m_timeout,
    output logic [15:0]                          job_cnt
);

    localparam int REF_SEQ_W  = 2 * REF_MAX_LENGTH;
    localparam int READ_SEQ_W = 2 * READ_MAX_LENGTH;
    localparam int REF_LEN_W  = $clog2(REF_MAX_LENGTH) + 1;
    localparam int READ_LEN_W = $clog2(READ_MAX_LENGTH) + 1;
    localparam int ROW_W      = $clog2(READ_MAX_LENGTH);
    localparam int COL_W      = $clog2(REF_MAX_LENGTH);
    localparam int BUF_W      = 2 * SEQ_W;
    localparam int WORDS      = BUF_W / WORD_W;
    localparam int CNT_W      = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int TMR_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int REF_PAD    = REF_SEQ_W - SEQ_W;
    localparam int READ_PAD   = READ_SEQ_W - SEQ_W;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef logic [REF_SEQ_W-1:0]  ref_vec_t;
    typedef logic [READ_SEQ_W-1:0] read_vec_t;
    typedef logic [REF_LEN_W-1:0]  ref_len_t;
    typedef logic [READ_LEN_W-1:0] read_len_t;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_OUT
    } state_e;

    typedef struct packed {
        logic signed [SCORE_W-1:0] score;
        logic [ROW_W-1:0]          row;
        logic [COL_W-1:0]          col;
        logic                      timeout;
    } result_t;

    state_e           state_q, state_d;
    logic             started_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    result_t          res_q, res_d;
    logic [15:0]      job_cnt_q, job_cnt_d;
    logic [BUF_W-1:0] buf_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_LOAD;
            started_q <= 1'b0;
            cnt_q     <= '0;
            tmr_q     <= '0;
            res_q     <= '0;
            job_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            res_q     <= res_d;
            job_cnt_q <= job_cnt_d;
        end
    end

    // NOTE: the job buffer has no reset; it is fully rewritten before each issue and the
    // core-facing outputs are gated to zero outside ISSUE, so its contents are never exposed.
    always_ff @(posedge clk) begin
        if (s_ready && s_valid) begin
            buf_q <= {buf_q[BUF_W-WORD_W-1:0], s_data};
        end
    end

    // NOTE: every output and next-state variable gets a default first, so no latches are inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmr_d       = tmr_q;
        res_d       = res_q;
        job_cnt_d   = job_cnt_q;
        s_ready     = 1'b0;
        sw_i_valid  = 1'b0;
        sw_i_ready  = 1'b0;
        sw_seq_ref  = '0;
        sw_seq_read = '0;
        sw_ref_len  = '0;
        sw_read_len = '0;
        m_valid     = 1'b0;

        case (state_q)
            ST_LOAD: begin
                // Held off for the first cycle out of reset.
                s_ready = started_q;
                if (started_q && s_valid) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_ISSUE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_ISSUE: begin
                sw_i_valid  = 1'b1;
                sw_seq_ref  = ref_vec_t'(buf_q[BUF_W-1 -: SEQ_W]) << REF_PAD;
                sw_seq_read = read_vec_t'(buf_q[SEQ_W-1:0]) << READ_PAD;
                sw_ref_len  = ref_len_t'(REF_LENGTH);
                sw_read_len = read_len_t'(READ_LENGTH);
                if (sw_o_ready) begin
                    tmr_d   = '0;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                sw_i_ready = 1'b1;
                // A result arriving on the timeout cycle takes priority over the timeout.
                if (sw_o_valid) begin
                    res_d.score   = sw_score;
                    res_d.row     = sw_row;
                    res_d.col     = sw_col;
                    res_d.timeout = 1'b0;
                    tmr_d         = '0;
                    state_d       = ST_OUT;
                end else if (TIMEOUT != 0 && tmr_q == TMR_LAST) begin
                    res_d         = '0;
                    res_d.timeout = 1'b1;
                    tmr_d         = '0;
                    state_d       = ST_OUT;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            ST_OUT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    job_cnt_d = job_cnt_q + 1'b1;
                    state_d   = ST_LOAD;
                end
            end

            default: state_d = ST_LOAD;
        endcase
    end

    assign m_score   = res_q.score;
    assign m_row     = res_q.row;
    assign m_col     = res_q.col;
    assign m_timeout = res_q.timeout;
    assign job_cnt   = job_cnt_q;

endmodule
